// File: rtl/right_barrel_shifter_8bits_pkg.sv
// Shared widths and types for the 8-bit right-rotate barrel shifter.
package right_barrel_shifter_8bits_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SHAMT_W = 3;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SHAMT_W-1:0] shamt_t;

endpackage : right_barrel_shifter_8bits_pkg

// File: rtl/right_barrel_shifter_8bits_rotr_stage.sv
// One log-shifter stage: rotates right by a fixed AMT when en is set, else passes through.
module rotr_stage
  import right_barrel_shifter_8bits_pkg::*;
#(
  parameter int unsigned AMT = 1
) (
  input  data_t in,
  input  logic  en,
  output data_t out
);

  localparam int unsigned DBL_W = 2 * DATA_W;

  logic [DBL_W-1:0] dbl;
  data_t            rot;

  // Doubling the word lets a plain slice express the wrap-around.
  assign dbl = {in, in};
  assign rot = dbl[AMT +: DATA_W];
  assign out = en ? rot : in;

endmodule : rotr_stage

// File: rtl/right_barrel_shifter_8bits.sv
// 8-bit rotate-right by 0..7 through a 1/2/4 mux cascade, with a single output register.
module right_barrel_shifter_8bits
  import right_barrel_shifter_8bits_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  data_t  D,
  input  shamt_t s,
  output data_t  Q
);

  data_t stage0;
  data_t stage1;
  data_t q_d;
  data_t q_q;

  rotr_stage #(.AMT(1)) u_rotr_1 (
    .in  (D),
    .en  (s[0]),
    .out (stage0)
  );

  rotr_stage #(.AMT(2)) u_rotr_2 (
    .in  (stage0),
    .en  (s[1]),
    .out (stage1)
  );

  rotr_stage #(.AMT(4)) u_rotr_4 (
    .in  (stage1),
    .en  (s[2]),
    .out (q_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= DATA_W'(0);
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule : right_barrel_shifter_8bits

// File: tb/tb_right_barrel_shifter_8bits.sv
// Directed and exhaustive checks of the registered 8-bit rotate-right.
module tb_right_barrel_shifter_8bits;
  import right_barrel_shifter_8bits_pkg::*;

  logic   clk;
  logic   rst_n;
  data_t  D;
  shamt_t s;
  data_t  Q;

  int unsigned n_checks;
  int unsigned n_pass;

  right_barrel_shifter_8bits dut (
    .clk   (clk),
    .rst_n (rst_n),
    .D     (D),
    .s     (s),
    .Q     (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-wise reference: Q[i] = D[(i + s) mod 8].
  function automatic data_t rotr_ref(input data_t d, input shamt_t sh);
    data_t r;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[(i + int'(sh)) % 8];
    end
    return r;
  endfunction

  task automatic check(input string tag, input data_t got, input data_t exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, return 1ns after the next rising edge.
  task automatic drive(input data_t d, input shamt_t sh);
    @(negedge clk);
    D = d;
    s = sh;
    @(posedge clk);
    #1;
  endtask

  data_t sweep_exp [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    sweep_exp = '{8'h0F, 8'h87, 8'hC3, 8'hE1, 8'hF0, 8'h78, 8'h3C, 8'h1E};

    // Asynchronous reset before any clock edge
    rst_n = 1'b1;
    D     = 8'h0F;
    s     = 3'd3;
    #1 rst_n = 1'b0;
    #1 check("reset_async", Q, 8'h00);
    @(posedge clk); #1;
    check("reset_hold", Q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release", Q, 8'hE1);

    // Sweep s on 0F
    for (int i = 0; i < 8; i++) begin
      drive(8'h0F, shamt_t'(i));
      check($sformatf("sweep_0F_s%0d", i), Q, sweep_exp[i]);
    end

    drive(8'hCC, 3'd0);
    check("cc_s0", Q, 8'hCC);
    drive(8'hCC, 3'd5);
    check("cc_s5", Q, 8'h66);

    // Latency: mid-cycle input change must not reach Q before the edge
    drive(8'h0F, 3'd4);
    check("lat_before", Q, 8'hF0);
    #1;
    D = 8'hF0;
    s = 3'd1;
    #2;
    check("lat_hold", Q, 8'hF0);
    @(posedge clk); #1;
    check("lat_update", Q, 8'h78);

    // Invariant words
    for (int i = 0; i < 8; i++) begin
      drive(8'h00, shamt_t'(i));
      check($sformatf("zero_s%0d", i), Q, 8'h00);
      drive(8'hFF, shamt_t'(i));
      check($sformatf("ones_s%0d", i), Q, 8'hFF);
    end

    // Exhaustive against the reference model
    for (int d = 0; d < 256; d++) begin
      for (int k = 0; k < 8; k++) begin
        drive(data_t'(d), shamt_t'(k));
        check($sformatf("exh_%02h_s%0d", d, k), Q, rotr_ref(data_t'(d), shamt_t'(k)));
      end
    end

    // Mid-stream reset during a sweep of A5
    drive(8'hA5, 3'd0);
    check("mid_s0", Q, 8'hA5);
    drive(8'hA5, 3'd1);
    check("mid_s1", Q, 8'hD2);
    #1 rst_n = 1'b0;
    #1 check("mid_async", Q, 8'h00);
    D = 8'hA5;
    s = 3'd2;
    @(posedge clk); #1;
    check("mid_hold", Q, 8'h00);
    @(negedge clk);
    D     = 8'hA5;
    s     = 3'd6;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_release", Q, 8'h96);
    drive(8'hA5, 3'd3);
    check("mid_resume", Q, 8'hB4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_right_barrel_shifter_8bits
